// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one UART transmitter between four requesters. Each requester owns a
// one-byte slot and a pending flag. A round-robin arbiter picks the next
// pending byte whenever the transmitter is idle. It issues a one-cycle start
// pulse and then waits for the transmitter's done pulse. If no done pulse
// arrives within TIMEOUT_CYCLES cycles of the start pulse, the byte is
// abandoned.
//
// Ports
//   clk           : single clock, rising edge
//   rst_n_i       : asynchronous active-low reset
//   req_i[3:0]    : one-cycle send strobe per requester
//   data0..3_i    : byte of requester k, sampled when req_i[k] = 1
//   pend_o[3:0]   : requester k holds an unsent byte
//   done_o[3:0]   : one-cycle pulse, requester k's byte completed
//   drop_o[3:0]   : one-cycle pulse, req_i[k] rejected because the slot is full
//   tx_start_o    : one-cycle start pulse to the transmitter
//   tx_data_o     : byte for the transmitter (held until the next grant)
//   tx_busy_i     : transmitter is shifting a frame
//   tx_done_i     : transmitter finished the stop bit (one-cycle pulse)
//   active_id_o   : index of the requester currently or last granted
//   timeout_o     : one-cycle pulse when a frame is abandoned
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 20_000_000
) (
  input  logic       clk,
  input  logic       rst_n_i,
  input  logic [3:0] req_i,
  input  logic [7:0] data0_i,
  input  logic [7:0] data1_i,
  input  logic [7:0] data2_i,
  input  logic [7:0] data3_i,
  output logic [3:0] pend_o,
  output logic [3:0] done_o,
  output logic [3:0] drop_o,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_busy_i,
  input  logic       tx_done_i,
  output logic [1:0] active_id_o,
  output logic       timeout_o
);

  // One extra bit beyond the limit, so the counter cannot wrap before the
  // limit is reached.
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [1:0]       last_grant;
  logic [7:0]       slot [4];
  logic [7:0]       data_in [4];

  logic             wait_done;
  logic             wait_expire;
  logic [3:0]       release_vec;
  logic [3:0]       accept_vec;
  logic [3:0]       reject_vec;
  logic             grant_valid;
  logic [1:0]       grant_id;

  // ---------------------------------------------------------------------------
  // Slot bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    data_in[0] = data0_i;
    data_in[1] = data1_i;
    data_in[2] = data2_i;
    data_in[3] = data3_i;
  end

  // The granted slot is released when its frame completes or times out. A
  // done pulse in the same cycle as expiry counts as a normal completion.
  assign wait_done   = (state == ST_WAIT) && tx_done_i;
  assign wait_expire = (state == ST_WAIT) && !tx_done_i && (tmo_cnt >= TMO_LAST);

  // NOTE: every combinational output gets a default before any conditional
  // update. Otherwise paths that skip the assignment would infer a latch.
  always_comb begin
    release_vec = '0;
    if (wait_done || wait_expire) begin
      release_vec[active_id_o] = 1'b1;
    end
  end

  // A request is accepted into an empty slot. It is also accepted into the
  // slot being released in this same cycle, so that requester can queue its
  // next byte without a gap.
  assign accept_vec = req_i & (~pend_o | release_vec);
  assign reject_vec = req_i & pend_o & ~release_vec;

  // NOTE: registered state is written with non-blocking assignments. Every
  // flop then samples the values from before the edge, whatever order the
  // always blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_o <= '0;
      drop_o <= '0;
    end else begin
      pend_o <= accept_vec | (pend_o & ~release_vec);
      drop_o <= reject_vec;
    end
  end

  // NOTE: the slot bytes carry no reset. A byte is only read while its pend
  // bit is set, and reset clears the pend bits, so stale contents are never
  // observed.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (accept_vec[k]) begin
        slot[k] <= data_in[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: search starts one past the last grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [1:0] cand;
    grant_valid = 1'b0;
    grant_id    = last_grant;
    cand        = last_grant;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!grant_valid && pend_o[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit sequencer
  // ---------------------------------------------------------------------------
  // tmo_cnt is cleared at the grant. It then counts one per cycle from the
  // start pulse onwards, so in WAIT it holds the number of cycles elapsed
  // since the start pulse. Expiry therefore lands exactly TIMEOUT_CYCLES
  // cycles after START.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      tx_start_o  <= 1'b0;
      tx_data_o   <= 8'h00;
      active_id_o <= 2'd0;
      done_o      <= '0;
      timeout_o   <= 1'b0;
      tmo_cnt     <= '0;
      last_grant  <= 2'd3;
    end else begin
      tx_start_o <= 1'b0;
      done_o     <= '0;
      timeout_o  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (grant_valid && !tx_busy_i) begin
            tx_start_o  <= 1'b1;
            tx_data_o   <= slot[grant_id];
            active_id_o <= grant_id;
            last_grant  <= grant_id;
            tmo_cnt     <= '0;
            state       <= ST_START;
          end
        end

        ST_START: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          state   <= ST_WAIT;
        end

        ST_WAIT: begin
          if (wait_done) begin
            done_o <= release_vec;
            state  <= ST_IDLE;
          end else if (wait_expire) begin
            timeout_o <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 20_000_000, max clk cycles to wait for tx_done_i after a start pulse before abandoning the byte.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-004 req_i  input  4  per-requester one-cycle send strobe; bit k belongs to requester k.
REQ-005 data0_i, data1_i, data2_i, data3_i  input  8 each  byte of requester k, sampled only in the cycle req_i[k]=1.
REQ-006 pend_o  output  4  bit k=1 while requester k holds an unsent byte.
REQ-007 done_o  output  4  one-cycle pulse on bit k when requester k's byte completed.
REQ-008 drop_o  output  4  one-cycle pulse on bit k when req_i[k] is rejected.
REQ-009 tx_start_o  output  1  one-cycle start pulse to the shared UART transmitter.
REQ-010 tx_data_o  output  8  byte for the transmitter.
REQ-011 tx_busy_i  input  1  transmitter currently shifting a frame.
REQ-012 tx_done_i  input  1  one-cycle pulse, transmitter finished stop bit.
REQ-013 active_id_o  output  2  index of requester currently granted.
REQ-014 timeout_o  output  1  one-cycle pulse when TIMEOUT_CYCLES expires.

Function
REQ-015 Each requester SHALL own a one-byte slot plus pend bit; req_i[k] with pend[k]=0 captures data_k_i into slot k and sets pend[k] next cycle.
REQ-016 req_i[k] with pend[k]=1 SHALL leave slot k unchanged and pulse drop_o[k] next cycle, except per REQ-024.
REQ-017 FSM states SHALL be IDLE, START, WAIT; encoding free.
REQ-018 IDLE: if any pend bit set and tx_busy_i=0, select winner, load tx_data_o from its slot, set active_id_o, go START; otherwise stay IDLE.
REQ-019 Arbitration SHALL be round-robin: search order starts at last_grant+1 mod 4; last_grant updates on grant.
REQ-020 START: tx_start_o=1 for exactly this one cycle, timeout counter cleared, go WAIT.
REQ-021 WAIT: on tx_done_i=1 clear pend[sel], pulse done_o[sel] next cycle, go IDLE; else increment counter.
REQ-022 WAIT: if counter reaches TIMEOUT_CYCLES-1 without tx_done_i, clear pend[sel], pulse timeout_o, no done_o, go IDLE; tx_done_i in same cycle takes priority (normal completion).
REQ-023 tx_data_o and active_id_o SHALL hold stable from START until next grant; tx_start_o=0 in all other states.
REQ-024 req_i[sel] in same cycle its pend is cleared (done or timeout) SHALL be accepted: new byte captured, pend stays 1, no drop_o.
REQ-025 Latency: req_i[k] in cycle N, FSM IDLE, tx_busy_i=0, no other pend -> tx_start_o=1 in cycle N+2.
REQ-026 tx_done_i while not in WAIT SHALL be ignored.
REQ-027 Multiple req_i bits in one cycle SHALL each be captured independently.
REQ-028 Timeout counter width SHALL be ceil(log2(TIMEOUT_CYCLES))+1 bits; no wrap before limit.

Reset
REQ-029 rst_n_i=0 SHALL immediately force: state IDLE, pend_o=0, done_o=0, drop_o=0, tx_start_o=0, tx_data_o=8'h00, active_id_o=2'd0, timeout_o=0, counter 0, last_grant=3 (requester 0 first).
REQ-030 Reset mid-frame SHALL discard all slots; no done_o pulse after release; first grant after release follows REQ-029 ordering.

Verification
REQ-031 Single: req_i=4'b0001, data0_i=8'h41 at cycle N -> tx_start_o=1 cycle N+2, tx_data_o=8'h41; tx_done_i pulse -> done_o=4'b0001 next cycle, pend_o=0.
REQ-032 Round-robin: req_i=4'b1111 with bytes 8'hA0..8'hA3 same cycle -> starts in order 0,1,2,3; then req 0 and 3 again after last_grant=3 -> order 0,3.
REQ-033 Drop: req_i[2] twice while pend[2]=1 (bytes 8'h11 then 8'h22) -> drop_o[2] pulse once, transmitted byte 8'h11.
REQ-034 Timeout: TIMEOUT_CYCLES=16, start pulse, no tx_done_i -> timeout_o pulse exactly 16 cycles after START, pend cleared, no done_o.
REQ-035 Busy hold: tx_busy_i=1 with pend_o=4'b0010 -> no tx_start_o until tx_busy_i falls; start 1 cycle after fall.
REQ-036 Reset mid-WAIT: rst_n_i low asynchronously between edges -> all outputs per REQ-029 immediately, later tx_done_i gives no done_o.
